// File: rtl/bram_arb_pkg.sv
// ---------------------------------------------------------------------------
// bram_arb_pkg
// Shared definitions for the two-requester BRAM arbiter.
//   - default address/data widths and lock hold limit
//   - requester index constants (bit positions in req/gnt vectors)
//   - arbiter FSM state encoding
// ---------------------------------------------------------------------------
package bram_arb_pkg;

   localparam int DEF_ADDR_W   = 8;
   localparam int DEF_DATA_W   = 16;
   localparam int DEF_LOCK_MAX = 15;

   // Bit positions of each requester inside the 2-bit req/gnt/mask vectors.
   localparam int REQ_A = 0;
   localparam int REQ_B = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_A = 2'd1,
      LOCK_B = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a priority pointer register.
// A requester only competes when its mask bit is 1 (the lock logic uses this
// to shut out the non-owner). When both eligible requesters ask, the pointer
// names the winner. After any grant the pointer moves to the requester that
// was not granted, so a lone requester cannot starve the other later on.
// Grants are forced to 0 while reset is asserted.
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   req    in   [1:0] request per requester (index REQ_A / REQ_B)
//   mask   in   [1:0] eligibility per requester
//   gnt    out  [1:0] one-hot (or zero) grant, combinational
//   ptr    out  current priority pointer (0 = A, 1 = B)
// ---------------------------------------------------------------------------
module rr_arb2
   import bram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic [1:0] mask,
   output logic [1:0] gnt,
   output logic       ptr
);

   logic [1:0] eligible;

   assign eligible = req & mask;

   always_comb begin
      gnt = 2'b00;
      if (rst_n) begin
         if (eligible == 2'b11) begin
            gnt[REQ_A] = (ptr == 1'(REQ_A));
            gnt[REQ_B] = (ptr == 1'(REQ_B));
         end else begin
            gnt = eligible;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= 1'(REQ_A);
      end else if (gnt[REQ_A]) begin
         ptr <= 1'(REQ_B);
      end else if (gnt[REQ_B]) begin
         ptr <= 1'(REQ_A);
      end
   end

endmodule

// File: rtl/bram_arbiter.sv
// ---------------------------------------------------------------------------
// bram_arbiter
// Shares one 1-cycle-registered-read BRAM between requesters A and B.
// At most one operation (read or write) is granted per cycle, round-robin
// between the two, with an optional lock that lets one requester keep the
// memory for an atomic read-modify-write sequence. Read data is routed back
// to the requester that issued the read one cycle after its grant.
//
// Handshake: an operation is accepted on a rising clock edge where
// o_x_gnt=1. o_x_gnt is combinational from i_x_req in the same cycle; the
// requester holds its request fields stable until it sees gnt. o_x_rvalid
// is a single-cycle strobe with no back-pressure.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_a_req/we/addr/wdata/lock  requester A operation (same for B)
//   o_a_gnt                   A accepted this cycle
//   o_a_rvalid, o_a_rdata     A read return (rdata is 0 when not valid)
//   o_mem_wr_en/waddr/wdata   BRAM write port
//   o_mem_rd_en/raddr         BRAM read port
//   i_mem_rdata               BRAM registered read data
//   o_lock_err                pulse during the op that hits the lock limit
//   o_state                   current FSM state (debug)
// ---------------------------------------------------------------------------
module bram_arbiter
   import bram_arb_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int LOCK_MAX = DEF_LOCK_MAX  // must be >= 2
)
(
   input  logic              i_clk,
   input  logic              i_rst_n,

   input  logic              i_a_req,
   input  logic              i_a_we,
   input  logic [ADDR_W-1:0] i_a_addr,
   input  logic [DATA_W-1:0] i_a_wdata,
   input  logic              i_a_lock,
   output logic              o_a_gnt,
   output logic              o_a_rvalid,
   output logic [DATA_W-1:0] o_a_rdata,

   input  logic              i_b_req,
   input  logic              i_b_we,
   input  logic [ADDR_W-1:0] i_b_addr,
   input  logic [DATA_W-1:0] i_b_wdata,
   input  logic              i_b_lock,
   output logic              o_b_gnt,
   output logic              o_b_rvalid,
   output logic [DATA_W-1:0] o_b_rdata,

   output logic              o_mem_wr_en,
   output logic [ADDR_W-1:0] o_mem_waddr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_mem_rd_en,
   output logic [ADDR_W-1:0] o_mem_raddr,
   input  logic [DATA_W-1:0] i_mem_rdata,

   output logic              o_lock_err,
   output logic [1:0]        o_state
);

   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   arb_state_e        state;
   arb_state_e        state_nxt;
   logic [CNT_W-1:0]  lock_cnt;
   logic [CNT_W-1:0]  lock_cnt_nxt;
   logic              lock_err;

   logic [1:0]        req;
   logic [1:0]        mask;
   logic [1:0]        gnt;
   logic              ptr;

   logic              sel_valid;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   logic [1:0]        rd_tag;

   // ------------------------------------------------------------------
   // Arbitration: the lock owner is the only eligible requester.
   // ------------------------------------------------------------------
   assign req[REQ_A] = i_a_req;
   assign req[REQ_B] = i_b_req;

   always_comb begin
      mask = 2'b11;
      case (state)
         LOCK_A:  mask = 2'b01 << REQ_A;
         LOCK_B:  mask = 2'b01 << REQ_B;
         default: mask = 2'b11;
      endcase
   end

   rr_arb2 u_rr_arb2 (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .req   (req),
      .mask  (mask),
      .gnt   (gnt),
      .ptr   (ptr)
   );

   assign o_a_gnt = gnt[REQ_A];
   assign o_b_gnt = gnt[REQ_B];

   // ------------------------------------------------------------------
   // Lock FSM. The counter holds the number of locked ops granted so far;
   // entering a lock counts as the first. The op that would bring the
   // count to LOCK_MAX is still performed, but ownership is dropped on
   // that edge and o_lock_err flags it in the same cycle. The pointer
   // needs no extra handling: after any owner grant it already names the
   // other requester.
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt    = state;
      lock_cnt_nxt = lock_cnt;
      lock_err     = 1'b0;
      case (state)
         IDLE: begin
            if (gnt[REQ_A] && i_a_lock) begin
               state_nxt    = LOCK_A;
               lock_cnt_nxt = CNT_W'(1);
            end else if (gnt[REQ_B] && i_b_lock) begin
               state_nxt    = LOCK_B;
               lock_cnt_nxt = CNT_W'(1);
            end
         end
         LOCK_A: begin
            if (!gnt[REQ_A] || !i_a_lock) begin
               state_nxt    = IDLE;
               lock_cnt_nxt = '0;
            end else if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
               state_nxt    = IDLE;
               lock_cnt_nxt = '0;
               lock_err     = 1'b1;
            end else begin
               lock_cnt_nxt = lock_cnt + CNT_W'(1);
            end
         end
         LOCK_B: begin
            if (!gnt[REQ_B] || !i_b_lock) begin
               state_nxt    = IDLE;
               lock_cnt_nxt = '0;
            end else if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
               state_nxt    = IDLE;
               lock_cnt_nxt = '0;
               lock_err     = 1'b1;
            end else begin
               lock_cnt_nxt = lock_cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt    = IDLE;
            lock_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         lock_cnt <= '0;
      end else begin
         state    <= state_nxt;
         lock_cnt <= lock_cnt_nxt;
      end
   end

   assign o_lock_err = lock_err;
   assign o_state    = state;

   // ------------------------------------------------------------------
   // Memory port mux: only the granted requester drives the BRAM; all
   // address/data outputs are 0 when the matching enable is low.
   // ------------------------------------------------------------------
   always_comb begin
      sel_valid = 1'b0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      if (gnt[REQ_A]) begin
         sel_valid = 1'b1;
         sel_we    = i_a_we;
         sel_addr  = i_a_addr;
         sel_wdata = i_a_wdata;
      end else if (gnt[REQ_B]) begin
         sel_valid = 1'b1;
         sel_we    = i_b_we;
         sel_addr  = i_b_addr;
         sel_wdata = i_b_wdata;
      end
   end

   assign o_mem_wr_en = sel_valid && sel_we;
   assign o_mem_rd_en = sel_valid && !sel_we;
   assign o_mem_waddr = o_mem_wr_en ? sel_addr  : '0;
   assign o_mem_wdata = o_mem_wr_en ? sel_wdata : '0;
   assign o_mem_raddr = o_mem_rd_en ? sel_addr  : '0;

   // ------------------------------------------------------------------
   // Read tag pipeline: remembers who issued the read so the BRAM's
   // registered data can be steered back one cycle later. Clearing it in
   // reset drops any read in flight.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_tag <= 2'b00;
      end else begin
         rd_tag[REQ_A] <= gnt[REQ_A] && !i_a_we;
         rd_tag[REQ_B] <= gnt[REQ_B] && !i_b_we;
      end
   end

   assign o_a_rvalid = rd_tag[REQ_A];
   assign o_b_rvalid = rd_tag[REQ_B];
   assign o_a_rdata  = rd_tag[REQ_A] ? i_mem_rdata : '0;
   assign o_b_rdata  = rd_tag[REQ_B] ? i_mem_rdata : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_arbiter
// Directed bench for bram_arbiter with a behavioural 256x16 BRAM attached to
// the memory ports. Read returns are also checked by a per-requester
// expected-data queue filled with hand-computed values at each read grant.
// ---------------------------------------------------------------------------
module tb_bram_arbiter;

   logic        i_clk;
   logic        i_rst_n;
   logic        a_req, a_we, a_lock;
   logic [7:0]  a_addr;
   logic [15:0] a_wdata;
   logic        b_req, b_we, b_lock;
   logic [7:0]  b_addr;
   logic [15:0] b_wdata;
   logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [15:0] a_rdata, b_rdata;
   logic        mem_wr_en, mem_rd_en;
   logic [7:0]  mem_waddr, mem_raddr;
   logic [15:0] mem_wdata, mem_rdata;
   logic        lock_err;
   logic [1:0]  state;

   int checks   = 0;
   int failures = 0;

   logic [15:0] a_exp_q[$];
   logic [15:0] b_exp_q[$];

   logic [15:0] mem_model [256];

   bram_arbiter #(.ADDR_W(8), .DATA_W(16), .LOCK_MAX(15)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_a_req     (a_req),
      .i_a_we      (a_we),
      .i_a_addr    (a_addr),
      .i_a_wdata   (a_wdata),
      .i_a_lock    (a_lock),
      .o_a_gnt     (a_gnt),
      .o_a_rvalid  (a_rvalid),
      .o_a_rdata   (a_rdata),
      .i_b_req     (b_req),
      .i_b_we      (b_we),
      .i_b_addr    (b_addr),
      .i_b_wdata   (b_wdata),
      .i_b_lock    (b_lock),
      .o_b_gnt     (b_gnt),
      .o_b_rvalid  (b_rvalid),
      .o_b_rdata   (b_rdata),
      .o_mem_wr_en (mem_wr_en),
      .o_mem_waddr (mem_waddr),
      .o_mem_wdata (mem_wdata),
      .o_mem_rd_en (mem_rd_en),
      .o_mem_raddr (mem_raddr),
      .i_mem_rdata (mem_rdata),
      .o_lock_err  (lock_err),
      .o_state     (state)
   );

   // ---------------- clock / reset / memory model ----------------
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      for (int i = 0; i < 256; i++) mem_model[i] = 16'h0000;
      mem_rdata = 16'h0000;
   end

   always @(posedge i_clk) begin
      if (mem_wr_en) mem_model[mem_waddr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= mem_model[mem_raddr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard for read returns, sampled mid-cycle.
   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         a_exp_q.delete();
         b_exp_q.delete();
      end else begin
         if (a_rvalid) begin
            if (a_exp_q.size() == 0) check("a_spurious_rvalid", 32'd1, 32'd0);
            else check("a_sb_rdata", {16'h0, a_rdata}, {16'h0, a_exp_q.pop_front()});
         end else begin
            check("a_rdata_idle", {16'h0, a_rdata}, 32'h0);
         end
         if (b_rvalid) begin
            if (b_exp_q.size() == 0) check("b_spurious_rvalid", 32'd1, 32'd0);
            else check("b_sb_rdata", {16'h0, b_rdata}, {16'h0, b_exp_q.pop_front()});
         end else begin
            check("b_rdata_idle", {16'h0, b_rdata}, 32'h0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_a(input logic req, input logic we, input logic [7:0] addr,
                          input logic [15:0] wdata, input logic lock);
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata; a_lock = lock;
   endtask

   task automatic drive_b(input logic req, input logic we, input logic [7:0] addr,
                          input logic [15:0] wdata, input logic lock);
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata; b_lock = lock;
   endtask

   task automatic idle_all();
      drive_a(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
      drive_b(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      idle_all();
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      i_rst_n = 1'b0;
      // Requests held high during reset must not be granted.
      drive_a(1'b1, 1'b0, 8'h10, 16'h0000, 1'b0);
      drive_b(1'b1, 1'b1, 8'h20, 16'h1234, 1'b0);
      #3;
      check("rst_a_gnt", a_gnt, 0);
      check("rst_b_gnt", b_gnt, 0);
      check("rst_wr_en", mem_wr_en, 0);
      check("rst_rd_en", mem_rd_en, 0);
      check("rst_rvalid", {a_rvalid, b_rvalid}, 0);
      check("rst_lock_err", lock_err, 0);
      check("rst_state", state, 0);
      do_reset();

      // --- writes then reads, one requester per cycle ---
      drive_a(1'b1, 1'b1, 8'hFF, 16'hBE11, 1'b0);
      #1;
      check("t1_a_gnt", a_gnt, 1);
      check("t1_wr_en", mem_wr_en, 1);
      check("t1_waddr", mem_waddr, 8'hFF);
      check("t1_wdata", mem_wdata, 16'hBE11);
      check("t1_rd_en", mem_rd_en, 0);
      tick();
      idle_all();
      drive_b(1'b1, 1'b1, 8'h95, 16'hC0DE, 1'b0);
      #1;
      check("t1_b_gnt", b_gnt, 1);
      check("t1_b_a_gnt", a_gnt, 0);
      check("t1_waddr_b", mem_waddr, 8'h95);
      tick();
      idle_all();
      drive_a(1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0);
      #1;
      check("t1_rd_en", mem_rd_en, 1);
      check("t1_raddr", mem_raddr, 8'hFF);
      check("t1_waddr_idle", mem_waddr, 8'h00);
      a_exp_q.push_back(16'hBE11);
      tick();
      check("t1_a_rvalid", a_rvalid, 1);
      check("t1_a_rdata", a_rdata, 16'hBE11);
      check("t1_b_no_rvalid", b_rvalid, 0);
      idle_all();
      drive_b(1'b1, 1'b0, 8'h95, 16'h0000, 1'b0);
      #1;
      check("t1_b_rd_gnt", b_gnt, 1);
      b_exp_q.push_back(16'hC0DE);
      tick();
      check("t1_b_rvalid", b_rvalid, 1);
      check("t1_b_rdata", b_rdata, 16'hC0DE);
      check("t1_a_no_rvalid", a_rvalid, 0);
      check("t1_a_rdata_zero", a_rdata, 0);
      idle_all();
      tick();

      // --- both read every cycle: strict alternation from A ---
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive_a(1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0);
         drive_b(1'b1, 1'b0, 8'h95, 16'h0000, 1'b0);
         #1;
         check("t2_a_gnt", a_gnt, (i % 2 == 0));
         check("t2_b_gnt", b_gnt, (i % 2 == 1));
         if (i % 2 == 0) a_exp_q.push_back(16'hBE11);
         else b_exp_q.push_back(16'hC0DE);
         tick();
         check("t2_a_rvalid", a_rvalid, (i % 2 == 0));
         check("t2_b_rvalid", b_rvalid, (i % 2 == 1));
      end
      idle_all();
      tick();

      // --- locked read-modify-write by A, B kept waiting ---
      drive_a(1'b1, 1'b0, 8'hFF, 16'h0000, 1'b1);
      drive_b(1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0);
      #1;
      check("t3_a_gnt_rd", a_gnt, 1);
      check("t3_b_gnt_rd", b_gnt, 0);
      a_exp_q.push_back(16'hBE11);
      tick();
      check("t3_state_lock_a", state, 1);
      drive_a(1'b1, 1'b1, 8'hFF, 16'hBE12, 1'b0);
      #1;
      check("t3_a_gnt_wr", a_gnt, 1);
      check("t3_b_gnt_wr", b_gnt, 0);
      check("t3_wdata", mem_wdata, 16'hBE12);
      tick();
      check("t3_state_idle", state, 0);
      drive_a(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
      #1;
      check("t3_b_gnt_after", b_gnt, 1);
      b_exp_q.push_back(16'hBE12);
      tick();
      check("t3_b_rdata", b_rdata, 16'hBE12);
      idle_all();

      // --- lock held past the limit: forced release on the 15th op ---
      for (int k = 1; k <= 20; k++) begin
         drive_a(1'b1, 1'b0, 8'h00, 16'h0000, 1'b1);
         drive_b(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0);
         #1;
         check("t4_a_gnt", a_gnt, (k != 16));
         check("t4_b_gnt", b_gnt, (k == 16));
         check("t4_lock_err", lock_err, (k == 15));
         if (k != 16) a_exp_q.push_back(16'h0000);
         else b_exp_q.push_back(16'h0000);
         tick();
      end
      idle_all();
      #1;
      check("t4_state_held", state, 1);
      check("t4_release_err", lock_err, 0);
      tick();
      check("t4_state_released", state, 0);

      // --- reset right after a B read grant drops the return ---
      drive_b(1'b1, 1'b0, 8'h95, 16'h0000, 1'b0);
      #1;
      check("t5_b_gnt", b_gnt, 1);
      tick();
      i_rst_n = 1'b0;
      #1;
      check("t5_b_rvalid_dropped", b_rvalid, 0);
      check("t5_b_gnt_in_rst", b_gnt, 0);
      check("t5_rd_en_in_rst", mem_rd_en, 0);
      idle_all();
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      drive_a(1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0);
      drive_b(1'b1, 1'b0, 8'h95, 16'h0000, 1'b0);
      #1;
      check("t5_a_first", a_gnt, 1);
      check("t5_b_second", b_gnt, 0);
      check("t5_b_rvalid_release", b_rvalid, 0);
      a_exp_q.push_back(16'hBE12);
      tick();
      check("t5_a_rvalid", a_rvalid, 1);
      check("t5_b_rvalid", b_rvalid, 0);
      idle_all();

      // --- B alone, back-to-back reads (FF holds BE12 after the RMW) ---
      drive_b(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0);
      #1;
      check("t6_b_gnt0", b_gnt, 1);
      b_exp_q.push_back(16'h0000);
      tick();
      check("t6_b_rvalid0", b_rvalid, 1);
      check("t6_b_rdata0", b_rdata, 16'h0000);
      drive_b(1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0);
      #1;
      check("t6_b_gnt1", b_gnt, 1);
      b_exp_q.push_back(16'hBE12);
      tick();
      check("t6_b_rvalid1", b_rvalid, 1);
      check("t6_b_rdata1", b_rdata, 16'hBE12);
      idle_all();
      tick();
      check("t6_b_rvalid_end", b_rvalid, 0);
      tick();

      check("a_queue_empty", a_exp_q.size(), 0);
      check("b_queue_empty", b_exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
